// File: rtl/uart_byte_receiver.sv
// 8N1 serial byte receiver: resynchronises the RXD pad and samples each bit at mid-bit.
// Received bytes are held on a valid/ready interface, with framing-error and overrun pulses.
module uart_byte_receiver #(
  parameter int CLOCKS_PER_BIT = 5208,
  parameter int HALF_BIT       = CLOCKS_PER_BIT / 2
) (
  input  logic       CLOCK_50M,
  input  logic       RESET_N,
  input  logic       RS232_DCE_RXD,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  input  logic       DATA_READY,
  output logic       FRAMING_ERROR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;
  logic             sync1_q, rx_s;
  logic             byte_done;
  logic             frame_bad;
  logic             take;

  // State register, synchroniser and output holding registers
  always_ff @(posedge CLOCK_50M) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      rx_s    <= 1'b0;
      state_q <= S_WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= RS232_DCE_RXD;
      rx_s    <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: cnt restarts from zero on every state change
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  // Output logic: a held byte is only replaced when it is being consumed this cycle
  always_comb begin
    take   = valid_q & DATA_READY;
    data_d = data_q;
    valid_d = valid_q;
    fe_d   = frame_bad;
    ovr_d  = 1'b0;
    BUSY   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    if (byte_done) begin
      if (!valid_q || take) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  assign DATA          = data_q;
  assign DATA_VALID    = valid_q;
  assign FRAMING_ERROR = fe_q;
  assign OVERRUN       = ovr_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: directed frames plus randomized traffic
// against a transaction-level model of what each frame should produce.
module tb_uart_byte_receiver;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = HALF + 9 * CPB + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, fe, ovr, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int fe_cyc = -1;
  int ovr_cyc = -1;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int exp_fe = 0;
  int exp_ovr = 0;
  int vcycles = 0;
  logic valid_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic held = 1'b0;
  logic ready_always = 1'b0;
  logic [7:0] exp_q[$];

  uart_byte_receiver #(.CLOCKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .CLOCK_50M    (clk),
    .RESET_N      (rst_n),
    .RS232_DCE_RXD(rxd),
    .DATA         (data),
    .DATA_VALID   (valid),
    .DATA_READY   (ready),
    .FRAMING_ERROR(fe),
    .OVERRUN      (ovr),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what a complete frame should produce, decided at transaction level
  function automatic void model(input logic [7:0] b, input logic stop);
    if (!stop) exp_fe++;
    else if (ready_always) exp_q.push_back(b);
    else if (held) exp_ovr++;
    else begin
      exp_q.push_back(b);
      held = 1'b1;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low = 0);
    model(b, stop);
    start_cyc = cyc;
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop;
    wait_cyc(CPB);
    if (!stop) wait_cyc(hold_low);
    rxd = 1'b1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    held = 1'b0;
    chk("valid_drop_after_take", valid, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every transfer and tracks flag pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && !valid_prev) rise_cyc = cyc;
      if (valid) vcycles++;
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
        else chk("byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      if (fe) begin
        fe_cnt++;
        fe_cyc = cyc;
        chk("fe_one_cycle", fe_prev, 1'b0);
      end
      if (ovr) begin
        ovr_cnt++;
        ovr_cyc = cyc;
        chk("ovr_one_cycle", ovr_prev, 1'b0);
      end
    end
    valid_prev = valid;
    fe_prev = fe;
    ovr_prev = ovr;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int v0, o0;
    logic [7:0] b;
    logic stop;

    wait_cyc(3);
    chk("reset_outputs", {data, valid, fe, ovr, busy}, 12'h000);
    rst_n = 1'b1;
    wait_cyc(5);

    // 1: held byte, latency, single-cycle accept
    send_frame(8'h42, 1'b1);
    chk("latency_valid", rise_cyc - start_cyc, LAT);
    wait_cyc(20);
    chk("held_valid", valid, 1'b1);
    chk("held_data", data, 8'h42);
    pulse_ready();
    wait_cyc(5);

    // 2: start-bit glitch rejected
    start_cyc = cyc;
    rxd = 1'b0;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      wait_cyc(1);
      if (k == 4) rxd = 1'b1;
      if (busy !== ((k >= 3) && (k <= 10))) bad++;
    end
    chk("glitch_busy_window", bad, 0);
    chk("glitch_no_valid", valid, 1'b0);
    chk("glitch_no_fe", fe_cnt, exp_fe);
    wait_cyc(5);

    // 4: overrun keeps first byte
    send_frame(8'h31, 1'b1);
    send_frame(8'h30, 1'b1);
    wait_cyc(2);
    chk("overrun_time", ovr_cyc - start_cyc, LAT);
    chk("overrun_data_kept", data, 8'h31);
    chk("overrun_valid", valid, 1'b1);
    pulse_ready();
    wait_cyc(4);
    chk("overrun_no_second", valid, 1'b0);

    // 3: framing error, line held low, recovery
    send_frame(8'h31, 1'b0, 100);
    chk("fe_time", fe_cyc - start_cyc, LAT);
    chk("fe_no_valid", valid, 1'b0);
    chk("fe_busy_low", busy, 1'b0);
    wait_cyc(20);
    send_frame(8'h55, 1'b1);
    wait_cyc(2);
    chk("recover_data", data, 8'h55);
    chk("recover_valid", valid, 1'b1);

    // 6: reset during bit 4 with a byte still held, then reset while line is low
    b = 8'hA5;
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = b[4];
    wait_cyc(8);
    rst_n = 1'b0;
    exp_q.delete();
    held = 1'b0;
    wait_cyc(1);
    chk("midframe_reset_outputs", {data, valid, fe, ovr, busy}, 12'h000);
    rxd = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      wait_cyc(1);
      if (busy !== 1'b0 || valid !== 1'b0 || fe !== 1'b0) bad++;
    end
    chk("low_line_after_reset", bad, 0);
    rxd = 1'b1;
    wait_cyc(20);
    send_frame(8'hA5, 1'b1);
    wait_cyc(2);
    chk("after_reset_data", data, 8'hA5);
    pulse_ready();

    // 5: always-ready back-to-back frames
    ready = 1'b1;
    ready_always = 1'b1;
    v0 = vcycles;
    o0 = ovr_cnt;
    send_frame(8'h01, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    wait_cyc(10);
    chk("b2b_valid_cycles", vcycles - v0, 3);
    chk("b2b_no_overrun", ovr_cnt, o0);

    // Randomized traffic, occasional bad stop bits
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      send_frame(b, stop);
      wait_cyc(stop ? $urandom_range(0, 20) : $urandom_range(2, 20));
    end

    wait_cyc(30);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("fe_count", fe_cnt, exp_fe);
    chk("ovr_count", ovr_cnt, exp_ovr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
